// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file
// with same-cycle write bypass and pending scoreboard.
module regfile_mp_sb #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  parameter  int NWR  = 1,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     pend_vec
);

  // x0 has no storage; entries exist for x1..x(NREG-1)
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] hit;
  logic [XLEN-1:0] hdat [NREG];

  // per-register write match; later ports override earlier ones
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      hit[r]  = 1'b0;
      hdat[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && r != 0 &&
            wr_addr[w*AW +: AW] == AW'(r)) begin
          hit[r]  = 1'b1;
          hdat[r] = wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // pending next state: issue set beats writeback clear
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (hit[r])
        pend_d[r] = 1'b0;
      if (iss_en && iss_rd == AW'(r))
        pend_d[r] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // storage write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < NREG; r++)
        regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (hit[r])
          regs_q[r] <= hdat[r];
    end
  end

  // pending bitmap register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign pend_vec = pend_q;

  // read ports: newest value wins; forced quiet in reset
  always_comb begin
    logic [AW-1:0] a;
    rd_data    = '0;
    rd_pending = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p*AW +: AW];
      if (resetn && a != '0) begin
        if (hit[a]) begin
          rd_data[p*XLEN +: XLEN] = hdat[a];
        end else begin
          rd_data[p*XLEN +: XLEN] = regs_q[a];
          rd_pending[p]           = pend_q[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: random + directed scoreboard bench
// for regfile_mp_sb with two read and two write ports.
module tb_regfile_mp_sb;

  logic         clk;
  logic         resetn;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_pending;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         iss_en;
  logic [4:0]   iss_rd;
  logic [31:0]  pend_vec;

  regfile_mp_sb #(
    .XLEN(64), .NREG(32), .NRD(2), .NWR(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pending(rd_pending),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .pend_vec  (pend_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic        p0;
    logic        p1;
    logic [31:0] pv;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] m_reg [32];
  bit          m_pend [32];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void chk(string n,
                              logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // one clock cycle: drive, predict, push, advance model
  task automatic cycle(input logic rn,
                       input logic [1:0] we,
                       input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input logic ie, input logic [4:0] ir,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    exp_t        e;
    logic [4:0]  wa [2];
    logic [63:0] wd [2];
    logic [4:0]  ra [2];
    logic [63:0] d  [2];
    logic        p  [2];
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    ra[0] = ra0; ra[1] = ra1;
    resetn  = rn;
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    iss_en  = ie;
    iss_rd  = ir;
    rd_addr = {ra1, ra0};
    if (!rn) model_clear();
    for (int i = 0; i < 2; i++) begin
      d[i] = '0;
      p[i] = 1'b0;
      if (rn && ra[i] != 0) begin
        d[i] = m_reg[ra[i]];
        p[i] = m_pend[ra[i]];
        for (int w = 0; w < 2; w++)
          if (we[w] && wa[w] == ra[i]) begin
            d[i] = wd[w];
            p[i] = 1'b0;
          end
      end
    end
    e.d0 = d[0]; e.d1 = d[1];
    e.p0 = p[0]; e.p1 = p[1];
    for (int i = 0; i < 32; i++) e.pv[i] = m_pend[i];
    sbq.push_back(e);
    @(posedge clk);
    if (rn) begin
      for (int w = 0; w < 2; w++)
        if (we[w] && wa[w] != 0) begin
          m_reg[wa[w]]  = wd[w];
          m_pend[wa[w]] = 1'b0;
        end
      if (ie && ir != 0) m_pend[ir] = 1'b1;
    end
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    cycle(1, 2'b00, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  // monitor: compare DUT outputs mid-cycle against queue head
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("rd_data0", rd_data[63:0], e.d0);
      chk("rd_data1", rd_data[127:64], e.d1);
      chk("rd_pend0", 64'(rd_pending[0]), 64'(e.p0));
      chk("rd_pend1", 64'(rd_pending[1]), 64'(e.p1));
      chk("pend_vec", 64'(pend_vec), 64'(e.pv));
    end
  end

  initial begin
    logic        rn;
    logic [1:0]  we;
    logic [4:0]  a [6];
    logic        ie;
    model_clear();
    resetn = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    iss_en = 0; iss_rd = 0; rd_addr = 0;
    @(posedge clk); #1;

    // writes and issues under reset are dropped
    cycle(0, 2'b11, 5, 6, 64'h55, 64'h66, 1, 5, 5, 6);
    cycle(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6);

    // async reset clears stored data and pending
    cycle(1, 2'b00, 0, 0, 0, 0, 1, 6, 5, 6);
    cycle(1, 2'b01, 5, 0, 64'hDEAD, 0, 1, 8, 5, 6);
    rd2(5, 6);
    cycle(0, 2'b01, 5, 0, 64'h77, 0, 0, 0, 5, 8);
    rd2(5, 8);

    // x0 stays zero and never pending
    cycle(1, 2'b11, 0, 0, '1, '1, 1, 0, 0, 0);
    rd2(0, 0);

    // bypass on both ports
    cycle(1, 2'b01, 7, 0, 64'h1, 0, 0, 0, 0, 0);
    cycle(1, 2'b01, 7, 0, 64'hABCD, 0, 0, 0, 7, 7);
    rd2(7, 7);

    // issue then later writeback of x3
    cycle(1, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0);
    rd2(3, 3);
    rd2(3, 0);
    rd2(0, 3);
    cycle(1, 2'b01, 3, 0, 64'h42, 0, 0, 0, 3, 3);
    rd2(3, 0);

    // same-cycle write and issue of x9
    cycle(1, 2'b10, 0, 9, 0, 64'h99, 1, 9, 9, 9);
    rd2(9, 0);

    // two ports write x4: port 1 wins
    cycle(1, 2'b11, 4, 4, 64'h11, 64'h22, 0, 0, 4, 4);
    rd2(4, 4);

    // randomized traffic with occasional reset
    for (int n = 0; n < 500; n++) begin
      rn = ($urandom_range(0, 63) != 0);
      we = 2'($urandom);
      for (int k = 0; k < 6; k++)
        a[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                    : 5'($urandom);
      ie = ($urandom_range(0, 2) == 0);
      cycle(rn, we, a[0], a[1],
            {$urandom, $urandom}, {$urandom, $urandom},
            ie, a[2], a[3], $urandom_range(0, 1) ? a[0] : a[4]);
    end
    rd2(0, 0);

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d left expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
